vga_pattern_gen: RTL and testbench
==================================

VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 SHALL have parameter vga_width, default 1024, meaning active pixels per line; it must be a power of two, at least 64.
REQ-002 SHALL have parameter vga_height, default 768, meaning active lines per frame.
REQ-003 SHALL have parameter color_depth, default 8, meaning bits per colour channel.
REQ-004 SHALL have parameters h_front_cnt 24, h_sync_cnt 136, h_back_cnt 144, meaning horizontal front-porch, sync and back-porch lengths in clocks.
REQ-005 SHALL have parameters v_front_cnt 3, v_sync_cnt 6, v_back_cnt 29, meaning vertical front-porch, sync and back-porch lengths in lines.
REQ-006 SHALL have parameter default_mode, default 1, meaning the pattern selected at reset.
REQ-007 SHALL have port clk, input, 1 bit: the pixel clock, the single clock; all state changes on its rising edge.
REQ-008 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-009 SHALL have port mode_req, input, 2 bits: the requested pattern.
REQ-010 SHALL have port mode_valid, input, 1 bit: mode_req is valid.
REQ-011 SHALL have port mode_ready, output, 1 bit: the block can accept a request.
REQ-012 SHALL have port cur_mode, output, 2 bits: the pattern currently displayed.
REQ-013 SHALL have ports vga_r, vga_g, vga_b, output, color_depth bits each: pixel data that feeds the downstream VGA driver colour inputs.
REQ-014 SHALL have port frame_start, output, 1 bit: a one-cycle pulse on the first clock of each frame.

Function
REQ-015 SHALL keep counters ctr_h over 0..h_cnt-1 and ctr_v over 0..v_cnt-1, using the driver's region order (front porch, sync, back porch, active):
- h_cnt = h_front_cnt + h_sync_cnt + h_back_cnt + vga_width, which is 1328 at defaults.
- v_cnt = v_front_cnt + v_sync_cnt + v_back_cnt + vga_height, which is 806 at defaults.
REQ-016 SHALL step the counters as follows:
- ctr_h increments every clock.
- At ctr_h = h_cnt-1, ctr_h wraps to 0 and ctr_v increments.
- At (h_cnt-1, v_cnt-1), both counters wrap to (0,0).
REQ-017 SHALL define the active region and pixel coordinates as follows:
- active = (ctr_h >= h_addr_start) && (ctr_v >= v_addr_start).
- h_addr_start = 304 and v_addr_start = 38 at defaults.
- x = ctr_h - h_addr_start and y = ctr_v - v_addr_start.
REQ-018 SHALL register vga_r, vga_g and vga_b from the next counter values, so that the colour for position (ctr_h, ctr_v) is present in the same cycle the counters hold that position (zero apparent latency).
REQ-019 SHALL drive vga_r, vga_g and vga_b to 0 whenever not active.
REQ-020 SHALL produce the following patterns; "full" means all ones:
- Mode 0: solid white; all channels full.
- Mode 1: eight vertical bars; bar index = x*8/vga_width, which is x[9:7] at defaults.
- Mode 1 bar colours, indices 0..7: white, yellow, cyan, green, magenta, red, blue, black; each channel is full or 0.
- Mode 2: 32x32 checkerboard; white when x[5]^y[5] = 1, otherwise black.
- Mode 3: horizontal grey ramp; all channels = (x*2^color_depth)/vga_width truncated, which is x[9:2] at defaults.
REQ-021 SHALL set mode_ready = 1 exactly when the single-entry pending register is empty.
REQ-022 SHALL accept a request on a clock where mode_valid && mode_ready, capturing mode_req into pending; mode_valid while mode_ready = 0 is ignored and not stored.
REQ-023 SHALL apply a pending request only at frame wrap:
- On the wrap edge (counters at (h_cnt-1, v_cnt-1)), pending moves to cur_mode and pending clears.
- The new mode takes effect from the first cycle of the next frame.
REQ-024 SHALL, when a request is accepted on the wrap-edge cycle itself, store it in pending and apply it at the following wrap, not the current one.
REQ-025 SHALL keep cur_mode unchanged when no request is pending at wrap.
REQ-026 SHALL make frame_start a register that is high for exactly the one cycle with counters at (0,0) that follows a wrap; there is no pulse in the first cycle after reset release.

Reset
REQ-027 SHALL, while rst_n = 0, hold: ctr_h = 0, ctr_v = 0, cur_mode = default_mode, pending empty, mode_ready = 1, vga_r/g/b = 0, frame_start = 0.
REQ-028 SHALL, when reset asserts mid-frame or mid-handshake, discard any pending request; counting restarts at (0,0) on the first clock after release.

Verification
REQ-029 Release reset, then run one frame at defaults -> frame_start first pulses at cycle 1070368 after release, then every 1070368 cycles; rgb = 0 at every non-active position.
REQ-030 Mode 1, line ctr_v = 38 -> ctr_h 304..431 gives rgb all 0xFF; ctr_h 432 gives (FF,FF,00); ctr_h 1200..1327 gives (00,00,00); ctr_h 303 gives 0.
REQ-031 Mode 2, then mode 3 -> at x = 32, y = 0 rgb = FF; at x = 32, y = 32 rgb = 00; in mode 3, x = 1023 gives 0xFF and x = 4 gives 0x01.
REQ-032 Issue mode_valid with mode_req = 2 mid-frame -> mode_ready drops next cycle; a second request with mode_req = 0 is ignored; cur_mode = 2 from the next frame; mode_ready returns to 1.
REQ-033 Issue a request exactly on the wrap cycle -> cur_mode is unchanged for that frame and changes at the following wrap.
REQ-034 Assert rst_n low mid-frame with a request pending -> all outputs go to their reset values asynchronously; after release cur_mode = default_mode and mode_ready = 1.

Source files
------------

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: raster counters, four colour patterns and a
// single-entry mode request that takes effect at the next frame boundary.
module vga_pattern_gen #(
  parameter int vga_width    = 1024,
  parameter int vga_height   = 768,
  parameter int color_depth  = 8,
  parameter int h_front_cnt  = 24,
  parameter int h_sync_cnt   = 136,
  parameter int h_back_cnt   = 144,
  parameter int v_front_cnt  = 3,
  parameter int v_sync_cnt   = 6,
  parameter int v_back_cnt   = 29,
  parameter int default_mode = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             mode_req,
  input  logic                   mode_valid,
  output logic                   mode_ready,
  output logic [1:0]             cur_mode,
  output logic [color_depth-1:0] vga_r,
  output logic [color_depth-1:0] vga_g,
  output logic [color_depth-1:0] vga_b,
  output logic                   frame_start
);

  localparam int HStart = h_front_cnt + h_sync_cnt + h_back_cnt;
  localparam int VStart = v_front_cnt + v_sync_cnt + v_back_cnt;
  localparam int HCnt   = HStart + vga_width;
  localparam int VCnt   = VStart + vga_height;
  localparam int HW     = $clog2(HCnt);
  localparam int VW     = $clog2(VCnt);
  localparam int XW     = $clog2(vga_width);
  localparam int CD     = color_depth;
  localparam logic [CD-1:0] Full = '1;

  logic [HW-1:0] ctr_h_q, ctr_h_d;
  logic [VW-1:0] ctr_v_q, ctr_v_d;
  logic [1:0]    mode_q, mode_d;
  logic [1:0]    pend_q, pend_d;
  logic          pend_v_q, pend_v_d;
  logic          fs_q;
  logic [CD-1:0] r_q, g_q, b_q;
  logic [CD-1:0] r_d, g_d, b_d;
  logic          h_end, wrap;
  logic          act_d;
  logic [XW-1:0] x;
  logic [VW-1:0] y;
  logic [2:0]    bar;
  logic          cb;
  logic [CD-1:0] grey;

  assign h_end = (ctr_h_q == HW'(HCnt - 1));
  assign wrap  = h_end && (ctr_v_q == VW'(VCnt - 1));

  always_comb begin
    ctr_h_d = h_end ? '0 : ctr_h_q + 1'b1;
    ctr_v_d = ctr_v_q;
    if (h_end) ctr_v_d = wrap ? '0 : ctr_v_q + 1'b1;
  end

  // A request captured on the wrap edge itself waits for the next wrap.
  always_comb begin
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    mode_d   = mode_q;
    if (wrap && pend_v_q) begin
      mode_d   = pend_q;
      pend_v_d = 1'b0;
    end else if (mode_valid && !pend_v_q) begin
      pend_d   = mode_req;
      pend_v_d = 1'b1;
    end
  end

  // Colour is computed for the next position so it lines up with the counters.
  assign act_d = (ctr_h_d >= HW'(HStart)) && (ctr_v_d >= VW'(VStart));
  assign x     = XW'(ctr_h_d - HW'(HStart));
  assign y     = ctr_v_d - VW'(VStart);
  assign bar   = 3'(x >> (XW - 3));
  assign cb    = |((32'(x) ^ 32'(y)) & 32'h20);
  assign grey  = CD'({x, {CD{1'b0}}} >> XW);

  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (act_d) begin
      unique case (mode_d)
        2'd0: begin
          r_d = Full;
          g_d = Full;
          b_d = Full;
        end
        2'd1: begin
          r_d = {CD{~bar[1]}};
          g_d = {CD{~bar[2]}};
          b_d = {CD{~bar[0]}};
        end
        2'd2: begin
          r_d = {CD{cb}};
          g_d = {CD{cb}};
          b_d = {CD{cb}};
        end
        2'd3: begin
          r_d = grey;
          g_d = grey;
          b_d = grey;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr_h_q  <= '0;
      ctr_v_q  <= '0;
      mode_q   <= 2'(default_mode);
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      fs_q     <= 1'b0;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
    end else begin
      ctr_h_q  <= ctr_h_d;
      ctr_v_q  <= ctr_v_d;
      mode_q   <= mode_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      fs_q     <= wrap;
      r_q      <= r_d;
      g_q      <= g_d;
      b_q      <= b_d;
    end
  end

  assign mode_ready  = ~pend_v_q;
  assign cur_mode    = mode_q;
  assign frame_start = fs_q;
  assign vga_r       = r_q;
  assign vga_g       = g_q;
  assign vga_b       = b_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: small raster, random mode requests, checked
// against a position/mode model built from the pattern definitions.
module tb_vga_pattern_gen;

  localparam int W  = 64;
  localparam int H  = 34;
  localparam int HF = 2, HSY = 3, HB = 3;
  localparam int VF = 1, VSY = 1, VB = 2;
  localparam int HS = HF + HSY + HB;
  localparam int VS = VF + VSY + VB;
  localparam int HC = HS + W;
  localparam int VC = VS + H;
  localparam int F  = HC * VC;
  localparam int DM = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode_req;
  logic       mode_valid;
  logic       mode_ready;
  logic [1:0] cur_mode;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       frame_start;

  vga_pattern_gen #(
    .vga_width(W), .vga_height(H), .color_depth(8),
    .h_front_cnt(HF), .h_sync_cnt(HSY), .h_back_cnt(HB),
    .v_front_cnt(VF), .v_sync_cnt(VSY), .v_back_cnt(VB),
    .default_mode(DM)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .mode_req(mode_req), .mode_valid(mode_valid),
    .mode_ready(mode_ready), .cur_mode(cur_mode),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  int         pos;
  int         k;
  bit         seen_fs;
  logic       mp_v;
  logic [1:0] mp;
  logic [1:0] mc;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h (pos=%0d)", tag, got, exp, pos);
    end
  endtask

  function automatic logic [23:0] exp_rgb(input int h, input int v,
                                          input int m);
    int x, y, c;
    if (h < HS || v < VS) return 24'h0;
    x = h - HS;
    y = v - VS;
    case (m)
      0: return 24'hFFFFFF;
      1: case (x * 8 / W)
           0: return 24'hFFFFFF;
           1: return 24'hFFFF00;
           2: return 24'h00FFFF;
           3: return 24'h00FF00;
           4: return 24'hFF00FF;
           5: return 24'hFF0000;
           6: return 24'h0000FF;
           default: return 24'h000000;
         endcase
      2: return (((x / 32) + (y / 32)) % 2 == 1) ? 24'hFFFFFF : 24'h0;
      default: begin
        c = x * 256 / W;
        return {c[7:0], c[7:0], c[7:0]};
      end
    endcase
  endfunction

  task automatic model_reset();
    pos = 0; k = 0; seen_fs = 0;
    mp_v = 1'b0; mp = 2'd0; mc = 2'(DM);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 0);
    chk({tag, "_fs"}, 32'(frame_start), 0);
    chk({tag, "_rdy"}, 32'(mode_ready), 1);
    chk({tag, "_mode"}, 32'(cur_mode), DM);
  endtask

  task automatic tick_check(input logic vld, input logic [1:0] req);
    int h, v;
    logic [23:0] rgb;
    @(posedge clk);
    if (pos == F - 1 && mp_v) begin
      mc = mp;
      mp_v = 1'b0;
    end else if (vld && !mp_v) begin
      mp = req;
      mp_v = 1'b1;
    end
    pos = (pos + 1) % F;
    k++;
    #1;
    h = pos % HC;
    v = pos / HC;
    rgb = {vga_r, vga_g, vga_b};
    chk("rgb", rgb, exp_rgb(h, v, mc));
    chk("fs", 32'(frame_start), (pos == 0) ? 1 : 0);
    chk("rdy", 32'(mode_ready), mp_v ? 0 : 1);
    chk("mode", 32'(cur_mode), 32'(mc));
    if (frame_start && !seen_fs) begin
      seen_fs = 1;
      chk("first_fs", k, F);
    end
    if (v == VS && mc == 1 && h == HS) chk("bar0", rgb, 24'hFFFFFF);
    if (v == VS && mc == 1 && h == HS + 8) chk("bar1", rgb, 24'hFFFF00);
    if (v == VS && mc == 1 && h == HS - 1) chk("hblank", rgb, 0);
    if (v == VS && mc == 1 && h == HC - 1) chk("bar7", rgb, 0);
    if (v == VS && mc == 2 && h == HS + 32) chk("cb_w", rgb, 24'hFFFFFF);
    if (v == VS + 32 && mc == 2 && h == HS + 32) chk("cb_b", rgb, 0);
    if (v == VS && mc == 3 && h == HS + 63) chk("ramp_max", rgb, 24'hFCFCFC);
    if (v == VS && mc == 3 && h == HS + 4) chk("ramp4", rgb, 24'h101010);
  endtask

  task automatic step(input logic vld, input logic [1:0] req);
    @(negedge clk);
    mode_valid = vld;
    mode_req   = req;
    tick_check(vld, req);
  endtask

  task automatic run_to(input int t);
    for (int n = 0; n < F + 2 && pos != t; n++) step(1'b0, 2'd0);
    chk("run_to", pos, t);
  endtask

  initial begin
    rst_n = 1'b0;
    mode_valid = 1'b0;
    mode_req = 2'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 chk_reset_vals("rst");
    mode_valid = 1'b1;
    @(posedge clk);
    #1 chk("rst_rdy_hold", 32'(mode_ready), 1);

    @(negedge clk);
    mode_valid = 1'b0;
    rst_n = 1'b1;
    tick_check(1'b0, 2'd0);

    run_to(0);
    run_to(F / 2);
    step(1'b1, 2'd2);
    chk("rdy_drop", 32'(mode_ready), 0);
    step(1'b1, 2'd0);
    step(1'b0, 2'd0);
    chk("req_held", 32'(cur_mode), 1);
    run_to(0);
    chk("mode2", 32'(cur_mode), 2);
    chk("rdy_back", 32'(mode_ready), 1);

    run_to(F / 3);
    step(1'b1, 2'd3);
    run_to(0);
    chk("mode3", 32'(cur_mode), 3);

    run_to(F - 1);
    step(1'b1, 2'd0);
    chk("wrap_hold", 32'(cur_mode), 3);
    chk("wrap_pend", 32'(mode_ready), 0);
    step(1'b0, 2'd0);
    run_to(0);
    chk("wrap_apply", 32'(cur_mode), 0);

    for (int i = 0; i < 4 * F; i++)
      step(($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
           2'($urandom_range(0, 3)));

    run_to((VS + 5) * HC + HS + 30);
    step(1'b1, 2'($urandom_range(0, 3)));
    step(1'b0, 2'd0);
    step(1'b0, 2'd0);
    chk("pre_rst_pend", 32'(mode_ready), 0);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("arst");
    model_reset();
    mode_valid = 1'b1;
    mode_req = 2'd2;
    @(posedge clk);
    #1 chk_reset_vals("arst_hold");
    @(negedge clk);
    mode_valid = 1'b0;
    rst_n = 1'b1;
    tick_check(1'b0, 2'd0);
    for (int i = 0; i < F + 5; i++) step(1'b0, 2'd0);
    chk("fs_after_rst", 32'(seen_fs), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
